// File: rtl/block_nest_pkg.sv
// Shared types and character helpers for the begin/end nesting checker.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package block_nest_pkg;

    // Keyword matcher states: one per matched prefix, plus word start and junk.
    typedef enum logic [3:0] {
        ST_WS,
        ST_B,
        ST_BE,
        ST_BEG,
        ST_BEGI,
        ST_BEGIN,
        ST_E,
        ST_EN,
        ST_END,
        ST_JUNK
    } match_state_t;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_TAB   = 8'h09;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;

    localparam logic [7:0] CH_B = 8'h62;
    localparam logic [7:0] CH_D = 8'h64;
    localparam logic [7:0] CH_E = 8'h65;
    localparam logic [7:0] CH_G = 8'h67;
    localparam logic [7:0] CH_I = 8'h69;
    localparam logic [7:0] CH_N = 8'h6E;

    localparam logic [7:0] CH_UPPER_A = 8'h41;
    localparam logic [7:0] CH_UPPER_Z = 8'h5A;

    // Fold A-Z onto a-z; every other byte passes through untouched.
    function automatic logic [7:0] to_lower(input logic [7:0] c);
        logic [7:0] r;
        r = c;
        if (c >= CH_UPPER_A && c <= CH_UPPER_Z) begin
            r = c | 8'h20;
        end
        return r;
    endfunction

    // Word separator test; with multi clear only the space separates words.
    function automatic logic is_delim(input logic [7:0] c, input logic multi);
        logic r;
        r = (c == CH_SPACE);
        if (multi) begin
            r = r || (c == CH_TAB) || (c == CH_LF) || (c == CH_CR);
        end
        return r;
    endfunction

endpackage

// File: rtl/keyword_matcher.sv
// Character FSM recognising whole-word "begin"/"end" (case-insensitive).
// Latency: commit pulses are combinational in the delimiter cycle; state updates on the clock edge.
// Backpressure: none; every in_valid cycle is consumed, in_valid=0 holds the state.
module keyword_matcher
    import block_nest_pkg::*;
#(
    parameter bit MULTI_DELIM = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       in_valid,
    input  logic [7:0] in,
    output logic       commit_begin,
    output logic       commit_end,
    output logic       pend_begin,
    output logic       pend_end
);

    match_state_t state_q;
    match_state_t state_d;
    logic [7:0]   ch;
    logic         delim;

    // Next-state and commit decode; clear drops the current character.
    always_comb begin
        ch           = to_lower(in);
        delim        = is_delim(in, MULTI_DELIM);
        state_d      = state_q;
        commit_begin = 1'b0;
        commit_end   = 1'b0;
        if (clear) begin
            state_d = ST_WS;
        end else if (in_valid) begin
            if (delim) begin
                state_d      = ST_WS;
                commit_begin = (state_q == ST_BEGIN);
                commit_end   = (state_q == ST_END);
            end else begin
                unique case (state_q)
                    ST_WS: begin
                        if (ch == CH_B) begin
                            state_d = ST_B;
                        end else if (ch == CH_E) begin
                            state_d = ST_E;
                        end else begin
                            state_d = ST_JUNK;
                        end
                    end
                    ST_B:    state_d = (ch == CH_E) ? ST_BE    : ST_JUNK;
                    ST_BE:   state_d = (ch == CH_G) ? ST_BEG   : ST_JUNK;
                    ST_BEG:  state_d = (ch == CH_I) ? ST_BEGI  : ST_JUNK;
                    ST_BEGI: state_d = (ch == CH_N) ? ST_BEGIN : ST_JUNK;
                    ST_E:    state_d = (ch == CH_N) ? ST_EN    : ST_JUNK;
                    ST_EN:   state_d = (ch == CH_D) ? ST_END   : ST_JUNK;
                    default: state_d = ST_JUNK;
                endcase
            end
        end
    end

    // State register; reset mid-word discards the partial word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_WS;
        end else begin
            state_q <= state_d;
        end
    end

    assign pend_begin = (state_q == ST_BEGIN);
    assign pend_end   = (state_q == ST_END);

endmodule

// File: rtl/block_nest_checker.sv
// Streaming begin/end nesting checker with saturating depth and sticky error flags.
// Latency: result/depth reflect the last accepted character right after its clock edge.
// Backpressure: none; a character is consumed on every in_valid cycle not masked by clear.
module block_nest_checker
    import block_nest_pkg::*;
#(
    parameter int unsigned DEPTH_W     = 8,
    parameter bit          STRICT      = 1'b1,
    parameter bit          MULTI_DELIM = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               in_valid,
    input  logic [7:0]         in,
    output logic               result,
    output logic [DEPTH_W-1:0] depth,
    output logic               underflow,
    output logic               overflow
);

    localparam logic [DEPTH_W-1:0]      MAX_DEPTH = '1;
    localparam logic [DEPTH_W-1:0]      DEPTH_ONE = 1;
    localparam logic signed [DEPTH_W:0] DEFF_ONE  = 1;

    logic               commit_begin;
    logic               commit_end;
    logic               pend_begin;
    logic               pend_end;

    logic [DEPTH_W-1:0] depth_q;
    logic [DEPTH_W-1:0] depth_d;
    logic               underflow_q;
    logic               underflow_d;
    logic               overflow_q;
    logic               overflow_d;

    logic signed [DEPTH_W:0] deff;

    keyword_matcher #(
        .MULTI_DELIM (MULTI_DELIM)
    ) u_matcher (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .in_valid     (in_valid),
        .in           (in),
        .commit_begin (commit_begin),
        .commit_end   (commit_end),
        .pend_begin   (pend_begin),
        .pend_end     (pend_end)
    );

    // Depth/flag update on keyword commit; saturate at the ends instead of wrapping.
    always_comb begin
        depth_d     = depth_q;
        underflow_d = underflow_q;
        overflow_d  = overflow_q;
        if (clear) begin
            depth_d     = '0;
            underflow_d = 1'b0;
            overflow_d  = 1'b0;
        end else if (commit_begin) begin
            if (depth_q != MAX_DEPTH) begin
                depth_d = depth_q + DEPTH_ONE;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (commit_end) begin
            if (depth_q != '0) begin
                depth_d = depth_q - DEPTH_ONE;
            end else if (STRICT) begin
                underflow_d = 1'b1;
            end
        end
    end

    // Committed depth and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            depth_q     <= '0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            depth_q     <= depth_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
        end
    end

    // Effective depth counts an unterminated trailing keyword; registers only, no path from in.
    always_comb begin
        deff = signed'({1'b0, depth_q});
        if (pend_begin) begin
            deff = deff + DEFF_ONE;
        end else if (pend_end) begin
            if (!STRICT && depth_q == '0) begin
                deff = '0;
            end else begin
                deff = deff - DEFF_ONE;
            end
        end
    end

    assign result    = !underflow_q && !overflow_q && (deff == '0);
    assign depth     = depth_q;
    assign underflow = underflow_q;
    assign overflow  = overflow_q;

endmodule
